riscv_v_pipe_ctrl: RTL and testbench



---
 rtl/riscv_v_pkg.sv | 12 +
 rtl/riscv_v_pipe_ctrl_if.sv | 28 ++
 rtl/riscv_v_pipe_ctrl.sv | 110 +++++++++++
 tb/tb_riscv_v_pipe_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types: pipeline controller FSM states and depth limit.
package riscv_v_pkg;

  localparam int RISCV_V_PIPE_CTRL_MAX_STAGES = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } riscv_v_pipe_ctrl_state_e;

endpackage

// File: rtl/riscv_v_pipe_ctrl_if.sv
// Handshake, flush/drain and per-stage control bundle of the vector pipe controller.
interface riscv_v_pipe_ctrl_if #(
  parameter int NUM_STAGES = 3,
  parameter int CNT_W      = $clog2(NUM_STAGES + 1)
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic                  flush_req;
  logic                  drain_req;
  logic [NUM_STAGES-1:0] stage_en;
  logic                  stage_flush;
  logic [NUM_STAGES-1:0] stage_valid;
  logic [CNT_W-1:0]      occupancy;
  logic                  drained;

  // master is the controller itself; slave is the surrounding pipeline/issue side
  modport master (
    input  in_valid, out_ready, flush_req, drain_req,
    output in_ready, out_valid, stage_en, stage_flush, stage_valid, occupancy, drained
  );

  modport slave (
    output in_valid, out_ready, flush_req, drain_req,
    input  in_ready, out_valid, stage_en, stage_flush, stage_valid, occupancy, drained
  );
endinterface

// File: rtl/riscv_v_pipe_ctrl.sv
// Valid tracking, bubble-collapsing stage enables, flush and drain/halt sequencing
// for a NUM_STAGES-deep vector pipeline.
module riscv_v_pipe_ctrl
  import riscv_v_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int CNT_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_v_pipe_ctrl_if.master  bus
);

  logic [NUM_STAGES-1:0]    valid_q;
  logic [NUM_STAGES-1:0]    valid_d;
  riscv_v_pipe_ctrl_state_e state_q;
  riscv_v_pipe_ctrl_state_e state_d;
  logic [NUM_STAGES-1:0]    stage_en_s;
  logic                     in_ready_s;
  logic [CNT_W-1:0]         occ_s;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_STAGES-1:0] v);
    logic [CNT_W-1:0] c;
    c = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_STAGES; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  assign occ_s = popcount(valid_q);

  // Enable chain from the tail: a stage moves when empty or its successor moves
  always_comb begin
    stage_en_s = {NUM_STAGES{1'b0}};
    stage_en_s[NUM_STAGES-1] = !valid_q[NUM_STAGES-1] || bus.out_ready;
    for (int i = NUM_STAGES - 2; i >= 0; i--) begin
      stage_en_s[i] = !valid_q[i] || stage_en_s[i+1];
    end
  end

  // Next valid vector; flush wins over every load
  always_comb begin
    in_ready_s = stage_en_s[0] && (state_q == RUN) && !bus.flush_req;
    valid_d    = valid_q;
    if (stage_en_s[0]) begin
      valid_d[0] = bus.in_valid && in_ready_s;
    end else begin
      valid_d[0] = valid_q[0];
    end
    for (int i = 1; i < NUM_STAGES; i++) begin
      if (stage_en_s[i]) begin
        valid_d[i] = valid_q[i-1];
      end else begin
        valid_d[i] = valid_q[i];
      end
    end
    if (bus.flush_req) begin
      valid_d = {NUM_STAGES{1'b0}};
    end else begin
      valid_d = valid_d;
    end
  end

  // Drain/halt sequencing; a flush collapses straight to HALT or RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (bus.drain_req) state_d = DRAIN;
        else               state_d = RUN;
      end
      DRAIN: begin
        if (!bus.drain_req)               state_d = RUN;
        else if (occ_s == {CNT_W{1'b0}})  state_d = HALT;
        else                              state_d = DRAIN;
      end
      HALT: begin
        if (!bus.drain_req) state_d = RUN;
        else                state_d = HALT;
      end
      default: state_d = RUN;
    endcase
    if (bus.flush_req) begin
      state_d = bus.drain_req ? HALT : RUN;
    end else begin
      state_d = state_d;
    end
  end

  // State and valid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= {NUM_STAGES{1'b0}};
      state_q <= RUN;
    end else begin
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

  assign bus.stage_en    = stage_en_s;
  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = valid_q[NUM_STAGES-1] && !bus.flush_req;
  assign bus.stage_flush = bus.flush_req;
  assign bus.stage_valid = valid_q;
  assign bus.occupancy   = occ_s;
  assign bus.drained     = (state_q == HALT);

endmodule

// File: tb/tb_riscv_v_pipe_ctrl.sv
// Directed bench for riscv_v_pipe_ctrl (3 stages) with a slot-level reference model
// checked every negative edge plus hand-computed expectations.
module tb_riscv_v_pipe_ctrl;

  localparam int N = 3;
  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_HALT  = 2;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  riscv_v_pipe_ctrl_if #(.NUM_STAGES(N)) bus ();

  riscv_v_pipe_ctrl #(.NUM_STAGES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one occupancy flag per slot, slot 2 is the output end
  bit [N-1:0] mv     = '0;
  int         mstate = M_RUN;

  function automatic bit [N-1:0] m_en(input bit [N-1:0] v, input bit ordy);
    bit [N-1:0] e;
    for (int i = 0; i < N; i++) begin
      e[i] = ordy;
      for (int j = i; j < N; j++) if (!v[j]) e[i] = 1'b1;
    end
    return e;
  endfunction

  function automatic int m_cnt(input bit [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic bit m_in_ready(input bit [N-1:0] v, input int st, input bit ordy, input bit fl);
    bit [N-1:0] e;
    e = m_en(v, ordy);
    return e[0] && (st == M_RUN) && !fl;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit [N-1:0] e;
    bit [N-1:0] nv;
    int         ns;
    if (rst) begin
      mv     = '0;
      mstate = M_RUN;
    end else begin
      e  = m_en(mv, bus.out_ready);
      nv = mv;
      for (int i = 0; i < N; i++) begin
        if (e[i]) nv[i] = (i == 0) ? (bus.in_valid && m_in_ready(mv, mstate, bus.out_ready, bus.flush_req))
                                   : mv[i-1];
      end
      ns = mstate;
      if (bus.flush_req) ns = bus.drain_req ? M_HALT : M_RUN;
      else if (mstate == M_RUN && bus.drain_req) ns = M_DRAIN;
      else if (mstate == M_DRAIN && !bus.drain_req) ns = M_RUN;
      else if (mstate == M_DRAIN && m_cnt(mv) == 0) ns = M_HALT;
      else if (mstate == M_HALT && !bus.drain_req) ns = M_RUN;
      if (bus.flush_req) nv = '0;
      mv     = nv;
      mstate = ns;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("stage_valid", 32'(bus.stage_valid), 32'(mv));
    chk("stage_en",    32'(bus.stage_en),    32'(m_en(mv, bus.out_ready)));
    chk("in_ready",    32'(bus.in_ready),    32'(m_in_ready(mv, mstate, bus.out_ready, bus.flush_req)));
    chk("out_valid",   32'(bus.out_valid),   32'(mv[N-1] && !bus.flush_req));
    chk("stage_flush", 32'(bus.stage_flush), 32'(bus.flush_req));
    chk("occupancy",   32'(bus.occupancy),   32'(m_cnt(mv)));
    chk("drained",     32'(bus.drained),     32'(mstate == M_HALT));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush_req = 1'b0;
    bus.drain_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_valid",    32'(bus.stage_valid), 32'h0);
    chk("rst_en",       32'(bus.stage_en),    32'h7);
    chk("rst_in_ready", 32'(bus.in_ready),    32'h1);
    chk("rst_occ",      32'(bus.occupancy),   32'h0);

    // 1: streaming, latency and steady occupancy
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick(); tick();
    chk("t1_ovalid_e2", 32'(bus.out_valid), 32'h0);
    chk("t1_occ_e2",    32'(bus.occupancy), 32'h2);
    tick();
    chk("t1_ovalid_e3", 32'(bus.out_valid), 32'h1);
    chk("t1_occ_e3",    32'(bus.occupancy), 32'h3);
    tick();
    chk("t1_occ_e4",    32'(bus.occupancy), 32'h3);
    chk("t1_irdy_e4",   32'(bus.in_ready),  32'h1);

    // 2: bubble collapse and full-pipe stall (v goes 110 -> 101)
    bus.in_valid = 1'b0; tick();
    bus.in_valid = 1'b1; tick();
    chk("t2_v101", 32'(bus.stage_valid), 32'h5);
    bus.out_ready = 1'b0; #1;
    chk("t2_en011",  32'(bus.stage_en), 32'h3);
    chk("t2_irdy1",  32'(bus.in_ready), 32'h1);
    tick();
    chk("t2_v111",   32'(bus.stage_valid), 32'h7);
    chk("t2_en000",  32'(bus.stage_en),    32'h0);
    chk("t2_irdy0",  32'(bus.in_ready),    32'h0);

    // 3: flush pulse on a full pipe
    bus.out_ready = 1'b1; bus.flush_req = 1'b1; #1;
    chk("t3_sflush", 32'(bus.stage_flush), 32'h1);
    chk("t3_irdy",   32'(bus.in_ready),    32'h0);
    chk("t3_ovalid", 32'(bus.out_valid),   32'h0);
    tick();
    bus.flush_req = 1'b0; #1;
    chk("t3_occ",    32'(bus.occupancy), 32'h0);
    chk("t3_run",    32'(bus.in_ready),  32'h1);

    // 4: drain from v=110, then release
    tick(); tick();
    bus.in_valid = 1'b0; tick();
    chk("t4_v110", 32'(bus.stage_valid), 32'h6);
    bus.drain_req = 1'b1; tick();
    bus.in_valid = 1'b1; #1;
    chk("t4_irdy0", 32'(bus.in_ready),  32'h0);
    chk("t4_occ1",  32'(bus.occupancy), 32'h1);
    tick();
    chk("t4_occ0",  32'(bus.occupancy), 32'h0);
    chk("t4_drn0",  32'(bus.drained),   32'h0);
    tick();
    chk("t4_drn1",  32'(bus.drained),   32'h1);
    bus.drain_req = 1'b0; #1;
    chk("t4_halt_irdy", 32'(bus.in_ready), 32'h0);
    tick();
    chk("t4_run_irdy",  32'(bus.in_ready), 32'h1);
    chk("t4_run_drn",   32'(bus.drained),  32'h0);
    chk("t4_run_occ",   32'(bus.occupancy), 32'h0);

    // 5: flush during DRAIN with drain held goes to HALT
    bus.out_ready = 1'b0; tick();
    bus.drain_req = 1'b1; tick();
    bus.in_valid = 1'b0; #1;
    chk("t5_v011",  32'(bus.stage_valid), 32'h3);
    chk("t5_irdy0", 32'(bus.in_ready),    32'h0);
    bus.flush_req = 1'b1; tick();
    bus.flush_req = 1'b0; #1;
    chk("t5_drn1",  32'(bus.drained),   32'h1);
    chk("t5_occ0",  32'(bus.occupancy), 32'h0);
    bus.drain_req = 1'b0; tick();
    chk("t5_run",   32'(bus.in_ready),  32'h1);

    // 6: asynchronous reset mid-cycle with v=110
    bus.in_valid = 1'b1; tick(); tick();
    bus.in_valid = 1'b0; tick();
    chk("t6_v110", 32'(bus.stage_valid), 32'h6);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", 32'(bus.stage_valid), 32'h0);
    chk("t6_ovalid", 32'(bus.out_valid),  32'h0);
    chk("t6_occ",   32'(bus.occupancy),   32'h0);
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    chk("t6_acc_v",  32'(bus.stage_valid), 32'h1);
    chk("t6_acc_occ", 32'(bus.occupancy),  32'h1);
    tick(); tick();
    chk("t6_ovalid_after", 32'(bus.out_valid), 32'h1);
    bus.in_valid = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
